// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences a board-level shift register. A start request
// latches a pattern and a shift count, pulses sr_load for one cycle, then
// issues one sr_ena pulse per rising edge of the timebase tick until the
// programmed number of shifts has been issued, and ends with a done pulse.
//
// Ports
//   clk, areset          clock, asynchronous active-high reset
//   start, stop          sequence request / abort (stop wins)
//   tick                 timebase flag; each rising edge is one shift slot
//   pattern, num_shifts  latched when a start is accepted in IDLE
//   sr_load, sr_ena      shift register controls (never high together)
//   sr_data              latched pattern, stable while busy
//   busy, done           sequence active / one-cycle completion pulse
//   shift_cnt            shifts issued in the current sequence
//
// Build option: define SHIFT_SEQ_AUTO_RELOAD_EN to make DONE reload the
// latched pattern and repeat until stop or areset.

module shift_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             start,
    input  logic             stop,
    input  logic             tick,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] num_shifts,
    output logic             sr_load,
    output logic             sr_ena,
    output logic [WIDTH-1:0] sr_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] shift_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic             tick_q;
    logic             load_q;
    logic             ena_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_rise;

    // A held-high tick counts once: only the 0->1 transition is a slot.
    assign tick_rise = tick & ~tick_q;
    assign cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Pulse outputs default low every cycle; each state raises them for
    // the single cycle that follows the deciding edge.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= S_IDLE;
            tick_q  <= 1'b0;
            load_q  <= 1'b0;
            ena_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
        end else begin
            tick_q <= tick;
            load_q <= 1'b0;
            ena_q  <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        data_q  <= pattern;
                        num_q   <= num_shifts;
                        cnt_q   <= '0;
                        state_q <= S_LOAD;
                        load_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (num_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (tick_rise) begin
                        ena_q <= 1'b1;
                        cnt_q <= cnt_d;
                        // Finish on the same edge that issues the last shift.
                        if (cnt_d == num_q) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
`ifdef SHIFT_SEQ_AUTO_RELOAD_EN
                    if (stop) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_LOAD;
                        load_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
`else
                    state_q <= S_IDLE;
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sr_load   = load_q;
    assign sr_ena    = ena_q;
    assign sr_data   = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign shift_cnt = cnt_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl (WIDTH=4, CNT_W=4): directed
// scenarios plus randomized stimulus against a behavioural reference model.

module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       areset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] pattern = 4'd0;
    logic [3:0] num_shifts = 4'd0;
    logic       sr_load, sr_ena, busy, done;
    logic [3:0] sr_data, shift_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int n_load, n_ena, n_done;

    // Reference model: which phase the sequence is in, plus counters.
    bit         m_in_load, m_in_run, m_in_done, m_ena, m_tick_prev;
    int         m_cnt, m_num;
    logic [3:0] m_pat;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.WIDTH(4), .CNT_W(4)) dut (
        .clk        (clk),
        .areset     (areset),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .pattern    (pattern),
        .num_shifts (num_shifts),
        .sr_load    (sr_load),
        .sr_ena     (sr_ena),
        .sr_data    (sr_data),
        .busy       (busy),
        .done       (done),
        .shift_cnt  (shift_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_load = 0; m_in_run = 0; m_in_done = 0; m_ena = 0;
        m_tick_prev = 0; m_cnt = 0; m_num = 0; m_pat = 4'd0;
    endtask

    task automatic model_edge();
        bit rise, idle, nl, nr, nd, ne;
        rise = tick && !m_tick_prev;
        m_tick_prev = tick;
        idle = !m_in_load && !m_in_run && !m_in_done;
        nl = 0; nr = 0; nd = 0; ne = 0;
        if (idle) begin
            if (start && !stop) begin
                m_pat = pattern; m_num = int'(num_shifts); m_cnt = 0; nl = 1;
            end
        end else if (m_in_load) begin
            if (!stop) begin
                if (m_num == 0) nd = 1; else nr = 1;
            end
        end else if (m_in_run) begin
            if (!stop) begin
                nr = 1;
                if (rise) begin
                    ne = 1; m_cnt++;
                    if (m_cnt == m_num) begin nr = 0; nd = 1; end
                end
            end
        end else begin
`ifdef SHIFT_SEQ_AUTO_RELOAD_EN
            if (!stop) begin nl = 1; m_cnt = 0; end
`endif
        end
        m_in_load = nl; m_in_run = nr; m_in_done = nd; m_ena = ne;
    endtask

    task automatic check_outputs();
        chk("sr_load", 32'(sr_load), 32'(m_in_load));
        chk("sr_ena", 32'(sr_ena), 32'(m_ena));
        chk("busy", 32'(busy), 32'(m_in_load | m_in_run));
        chk("done", 32'(done), 32'(m_in_done));
        chk("sr_data", 32'(sr_data), 32'(m_pat));
        chk("shift_cnt", 32'(shift_cnt), 32'(m_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        if (!areset) model_edge();
        #1;
        check_outputs();
        if (sr_load) n_load++;
        if (sr_ena) n_ena++;
        if (done) n_done++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_counts();
        n_load = 0; n_ena = 0; n_done = 0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        areset = 1'b0;
    endtask

    task automatic go_idle();
        stop = 1'b1; start = 1'b0; tick = 1'b0;
        steps(2);
        stop = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic launch(input logic [3:0] p, input logic [3:0] n);
        clear_counts();
        pattern = p; num_shifts = n; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        model_reset();
        clear_counts();
        #2;
        do_reset();
        steps(2);

        // Basic sequence, tick rise every 5 cycles, re-start while busy.
        launch(4'b1010, 4'd3);
        chk("load_data", 32'(sr_data), 32'hA);
        for (int i = 0; i < 30; i++) begin
            tick = (i % 5 == 2);
            if (i == 4) begin start = 1'b1; pattern = 4'b0001; end
            else start = 1'b0;
            step();
        end
        tick = 1'b0;
        chk("data_kept", 32'(sr_data), 32'hA);
`ifndef SHIFT_SEQ_AUTO_RELOAD_EN
        chk("seq_loads", 32'(n_load), 32'd1);
        chk("seq_enas", 32'(n_ena), 32'd3);
        chk("seq_dones", 32'(n_done), 32'd1);
        chk("seq_cnt", 32'(shift_cnt), 32'd3);
`endif
        go_idle();

        // Zero-shift sequence: load then done, no enable.
        launch(4'b0110, 4'd0);
        chk("zero_load", 32'(sr_load), 32'd1);
        step();
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_ena", 32'(n_ena), 32'd0);
        chk("zero_cnt", 32'(shift_cnt), 32'd0);
        go_idle();

        // Stop coinciding with the second tick rise.
        launch(4'b1100, 4'd5);
        step();
        tick = 1'b1; step();
        tick = 1'b0; steps(2);
        tick = 1'b1; stop = 1'b1; step();
        tick = 1'b0; stop = 1'b0;
        chk("stop_cnt", 32'(shift_cnt), 32'd1);
        chk("stop_busy", 32'(busy), 32'd0);
        steps(5);
        chk("stop_enas", 32'(n_ena), 32'd1);
        chk("stop_dones", 32'(n_done), 32'd0);

        // Tick held high for 10 cycles gives a single enable.
        launch(4'b0011, 4'd3);
        step();
        tick = 1'b1; steps(10);
        tick = 1'b0; steps(4);
        chk("held_enas", 32'(n_ena), 32'd1);
        go_idle();

        // Asynchronous reset mid-run with two shifts done.
        launch(4'b1001, 4'd5);
        for (int i = 0; i < 40 && shift_cnt != 4'd2; i++) begin
            tick = (i % 3 == 1);
            step();
        end
        tick = 1'b0;
        chk("pre_reset_cnt", 32'(shift_cnt), 32'd2);
        do_reset();
        launch(4'b0101, 4'd1);
        chk("post_reset_load", 32'(sr_load), 32'd1);
        chk("post_reset_data", 32'(sr_data), 32'h5);
        go_idle();

`ifdef SHIFT_SEQ_AUTO_RELOAD_EN
        // Auto reload: three load/ena/ena/done iterations, then stop.
        launch(4'b1110, 4'd2);
        for (int i = 0; i < 100 && n_done < 3; i++) begin
            tick = (i % 3 == 0);
            step();
        end
        tick = 1'b0;
        chk("auto_dones", 32'(n_done), 32'd3);
        chk("auto_loads", 32'(n_load), 32'd3);
        chk("auto_enas", 32'(n_ena), 32'd6);
        stop = 1'b1; step(); stop = 1'b0;
        chk("auto_stop_busy", 32'(busy), 32'd0);
        steps(3);
        chk("auto_stop_idle", 32'(busy), 32'd0);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            start = ($urandom_range(0, 5) == 0);
            stop = ($urandom_range(0, 24) == 0);
            tick = ($urandom_range(0, 3) == 0);
            pattern = 4'($urandom_range(0, 15));
            num_shifts = 4'($urandom_range(0, 4));
            if (i % 10 == 0) num_shifts = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) do_reset();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
